instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 34 +++
 rtl/instruction_fetch_if_id_reg.sv | 60 ++++++
 rtl/instruction_fetch.sv | 135 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_pkg
//  Description : Shared pipeline definitions: fetch FSM encoding, the NOP
//                word, decoder opcode/funct constants and address helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

   // Fetch FSM states, 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } fetch_state_e;

   // Bubble word inserted into IF/ID
   localparam logic [31:0] C_NOP     = 32'h0000_0000;
   localparam logic [31:0] C_PC_STEP = 32'd4;

   // Opcode (instr[31:26]) and funct (instr[5:0]) values shared with the decoder
   localparam logic [5:0] C_OP_J     = 6'b000010;
   localparam logic [5:0] C_OP_JAL   = 6'b000011;
   localparam logic [5:0] C_FN_JR    = 6'b001000;
   localparam logic [5:0] C_FN_JALR  = 6'b001001;
   localparam logic [5:0] C_FN_FIN   = 6'b000001;

   // Redirect targets are always word addresses
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register holding instruction, PC+4 and a
//                valid flag. Flush inserts a NOP and wins over hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
   import instruction_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc4_in,
   output logic [31:0] instr_out,
   output logic [31:0] pc4_out,
   output logic        valid_out
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q,   pc4_d;
   logic        valid_q, valid_d;

   // Next contents: flush -> NOP, hold -> keep, otherwise capture the fetch
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush) begin
         instr_d = C_NOP;
         pc4_d   = 32'h0;
         valid_d = 1'b0;
      end else if (!hold) begin
         instr_d = instr_in;
         pc4_d   = pc4_in;
         valid_d = 1'b1;
      end
   end

   // Register update with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q <= C_NOP;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr_out = instr_q;
   assign pc4_out   = pc4_q;
   assign valid_out = valid_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Fetch stage: IDLE/RUN/HALT control FSM, PC with branch/jump
//                redirect and stall, IF/ID register and saturating fetch count.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic             jump,
   input  logic [31:0]      jump_target,
   input  logic             fin,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_data,
   output logic [31:0]      instr_out,
   output logic [31:0]      pc4_out,
   output logic             dec_enable,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
   logic             dec_enable_q, dec_enable_d;

   logic [31:0]      w_pc_plus4;
   logic             w_flush;
   logic             w_hold;
   logic             w_if_valid;

   assign w_pc_plus4 = pc_q + C_PC_STEP;   // 32-bit modulo wrap

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; HALT is left only through reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (fin)   state_d = ST_HALT;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath control: priority fin > branch > jump > stall > sequential
   always_comb begin
      pc_d          = pc_q;
      fetch_count_d = fetch_count_q;
      dec_enable_d  = dec_enable_q;
      w_flush       = 1'b0;
      w_hold        = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (fin) begin
               w_flush      = 1'b1;
               dec_enable_d = 1'b0;
            end else if (branch_taken) begin
               pc_d         = word_align(branch_target);
               w_flush      = 1'b1;
               dec_enable_d = 1'b0;
            end else if (jump) begin
               pc_d         = word_align(jump_target);
               w_flush      = 1'b1;
               dec_enable_d = 1'b0;
            end else if (stall) begin
               w_hold = 1'b1;
            end else begin
               pc_d          = w_pc_plus4;
               fetch_count_d = (&fetch_count_q) ? fetch_count_q
                                                : fetch_count_q + CNT_W'(1);
               // Enable follows the word already in IF/ID, so it rises one
               // cycle after the first valid fetch
               dec_enable_d  = w_if_valid;
            end
         end
         ST_HALT: begin
            w_flush      = 1'b1;
            dec_enable_d = 1'b0;
         end
         default: begin
            pc_d         = RESET_PC;
            w_flush      = 1'b1;
            dec_enable_d = 1'b0;
         end
      endcase
   end

   // PC, fetch counter and decoder-enable registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         fetch_count_q <= '0;
         dec_enable_q  <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         fetch_count_q <= fetch_count_d;
         dec_enable_q  <= dec_enable_d;
      end
   end

   if_id_reg u_if_id (
      .clk       (clk),
      .reset     (reset),
      .hold      (w_hold),
      .flush     (w_flush),
      .instr_in  (imem_data),
      .pc4_in    (w_pc_plus4),
      .instr_out (instr_out),
      .pc4_out   (pc4_out),
      .valid_out (w_if_valid)
   );

   assign imem_addr   = pc_q;
   assign dec_enable  = dec_enable_q;
   assign halted      = (state_q == ST_HALT);
   assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire
